// File: rtl/rp_driver.sv
// rp_driver -- static-region initiator for a reconfigurable arithmetic partition.
//
// Takes operand pairs on a valid/ready command interface, drives them to the
// partition's ain/bin ports, waits RP_LATENCY partition edges, captures the
// partition result and offers it on a valid/ready response interface. A
// decouple handshake isolates the partition (held in reset, operands zeroed)
// for partial reconfiguration, and never interrupts an operation in flight.
//
// Parameters:
//   DATA_W      operand / result width
//   RP_LATENCY  partition edges from operands stable to result valid (1..15)
//   CNT_W       width of op_count
//
// Ports:
//   Clk, Reset_n          clock, synchronous active-low reset
//   cmd_valid/cmd_ready   operand pair handshake (cmd_a, cmd_b)
//   rsp_valid/rsp_ready   result handshake (rsp_data)
//   decouple_req/ack      partition isolation request / acknowledge
//   rp_ain, rp_bin        operands to the partition
//   rp_reset_n            partition reset (low while decoupled or in reset)
//   rp_result             result from the partition, sampled only in WAIT
//   busy                  operation in flight (WAIT or RESP)
//   op_count              completed response handshakes, wraps
//   err                   sticky result-check error
//
// Build option:
//   RP_DRIVER_CHECK_EN  when defined, every captured result is compared with
//                       (cmd_a + cmd_b) mod 2^DATA_W and a mismatch sets err.
//                       When undefined, err is tied low.
module rp_driver #(
  parameter int DATA_W     = 32,
  parameter int RP_LATENCY = 1,
  parameter int CNT_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              decouple_req,
  output logic              decouple_ack,
  output logic [DATA_W-1:0] rp_ain,
  output logic [DATA_W-1:0] rp_bin,
  output logic              rp_reset_n,
  input  logic [DATA_W-1:0] rp_result,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count,
  output logic              err
);

  localparam logic [3:0] LAT = 4'(RP_LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DECOUPLED} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       accept;
  logic       capture;
  logic       rsp_hs;
  logic       dec_enter;

  // ---- state register ----
  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // ---- next-state logic ----
  // A decouple request seen in WAIT/RESP is not acted on there; the operation
  // finishes, returns to IDLE, and IDLE then moves to DECOUPLED because
  // cmd_ready is held low while the request is up.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_valid && !decouple_req) state_nxt = WAIT;
        else if (decouple_req)          state_nxt = DECOUPLED;
      end
      WAIT:      if (cnt == 4'd0)   state_nxt = RESP;
      RESP:      if (rsp_ready)     state_nxt = IDLE;
      DECOUPLED: if (!decouple_req) state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // ---- output / strobe logic ----
  always_comb begin
    cmd_ready = (state == IDLE) && !decouple_req;
    busy      = (state == WAIT) || (state == RESP);
    accept    = cmd_ready && cmd_valid;
    capture   = (state == WAIT) && (cnt == 4'd0);
    rsp_hs    = (state == RESP) && rsp_ready;
    dec_enter = (state != DECOUPLED) && (state_nxt == DECOUPLED);
  end

  // ---- datapath and registered outputs ----
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rp_ain       <= '0;
      rp_bin       <= '0;
      cnt          <= 4'd0;
      rsp_data     <= '0;
      rsp_valid    <= 1'b0;
      op_count     <= '0;
      decouple_ack <= 1'b0;
      rp_reset_n   <= 1'b0;
    end else begin
      if (accept) begin
        rp_ain <= cmd_a;
        rp_bin <= cmd_b;
        cnt    <= LAT;
      end else if (dec_enter) begin
        rp_ain <= '0;
        rp_bin <= '0;
      end

      if ((state == WAIT) && (cnt != 4'd0)) cnt <= cnt - 4'd1;

      if (capture) begin
        rsp_data  <= rp_result;
        rsp_valid <= 1'b1;
      end else if (rsp_hs) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + CNT_W'(1);
      end

      // Isolation outputs follow the state being entered, so they change on
      // the same edge as the transition into or out of DECOUPLED.
      decouple_ack <= (state_nxt == DECOUPLED);
      rp_reset_n   <= (state_nxt != DECOUPLED);
    end
  end

`ifdef RP_DRIVER_CHECK_EN
  function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  logic [DATA_W-1:0] expected;

  // ---- result checker ----
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      expected <= '0;
      err      <= 1'b0;
    end else begin
      if (accept)                             expected <= wrap_add(cmd_a, cmd_b);
      if (capture && (rp_result != expected)) err      <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/rp_driver.md
Name: rp_driver

Overview:
- Static-region initiator for a reconfigurable arithmetic partition: ports ain/bin/result plus a partition reset.
- Accepts operand pairs on a valid/ready command interface, drives them to the partition, waits a fixed partition latency, captures the result and returns it on a valid/ready response interface.
- Provides a decouple handshake so partial reconfiguration never overlaps an in-flight operation.

Parameters:
- DATA_W, 32, operand/result width
- RP_LATENCY, 1, partition clock edges from operands stable to result valid (1..15)
- CNT_W, 16, width of op_count

Ports:
- Clk  in  1  clock
- Reset_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  operand pair valid
- cmd_ready  out  1  driver can accept operand pair
- cmd_a  in  DATA_W  operand A
- cmd_b  in  DATA_W  operand B
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  DATA_W  captured result
- decouple_req  in  1  request to isolate partition for reconfiguration
- decouple_ack  out  1  partition isolated, safe to reconfigure
- rp_ain  out  DATA_W  to partition ain
- rp_bin  out  DATA_W  to partition bin
- rp_reset_n  out  1  to partition Reset_n
- rp_result  in  DATA_W  from partition result
- busy  out  1  operation in flight (state WAIT or RESP)
- op_count  out  CNT_W  completed response handshakes, wraps
- err  out  1  sticky result-check error (see Optional Feature)

Behaviour:
- Reset values (Reset_n low at a Clk edge): state IDLE, rp_ain=rp_bin=0, rsp_data=0, rsp_valid=0, decouple_ack=0, rp_reset_n=0, op_count=0, err=0, latency counter=0. rp_reset_n goes 1 at the first edge with Reset_n high.
- States: IDLE, WAIT, RESP, DECOUPLED.
- cmd_ready is combinational: 1 only when state==IDLE and decouple_req==0.
- IDLE:
  - On cmd_valid&&cmd_ready, register cmd_a/cmd_b into rp_ain/rp_bin, load cnt=RP_LATENCY, go to WAIT.
  - Otherwise, if decouple_req==1, go to DECOUPLED.
- WAIT:
  - If cnt!=0, decrement.
  - If cnt==0, register rp_result into rsp_data, set rsp_valid=1, go to RESP.
  - Command accept to rsp_valid high is RP_LATENCY+1 edges.
- RESP:
  - rsp_valid and rsp_data hold stable until rsp_valid&&rsp_ready.
  - On that handshake: clear rsp_valid, increment op_count (modulo 2^CNT_W), go to IDLE.
  - No new command is accepted in the same cycle, so peak throughput is one op per RP_LATENCY+3 cycles with rsp_ready tied high.
- decouple_req in WAIT or RESP: the operation completes normally, including the response handshake, then enters DECOUPLED. In-flight operations are never aborted.
- DECOUPLED:
  - decouple_ack=1, rp_reset_n=0, rp_ain=rp_bin=0 (registered on entry).
  - When decouple_req==0: decouple_ack=0, rp_reset_n=1, go to IDLE. cmd_ready can rise the cycle after.
- rp_result is ignored outside WAIT.
- Arithmetic: none in the datapath. Data passes through at DATA_W bits with no extension.
- Reset mid-operation: all state is cleared immediately and the pending result is discarded; no rsp_valid is produced.
- decouple_req and cmd_valid high together in IDLE: decouple wins, because cmd_ready is 0.

Optional Feature:
- Macro RP_DRIVER_CHECK_EN.
- Defined:
  - On accept, also register expected = (cmd_a+cmd_b) mod 2^DATA_W.
  - At the capture edge in WAIT, if rp_result!=expected, set err=1.
  - err is sticky until Reset_n.
  - Used to verify the adder personality after reconfiguration.
- Undefined: err tied to 0 and no checker logic is present.

Test Plan:
- Defaults, cmd 5/7, rsp_ready=1, adder partition -> rsp_data=12, rsp_valid rises 2 edges after accept, op_count=1.
- cmd 0xFFFFFFFF/0x00000001 -> rsp_data=0x00000000; err stays 0 with RP_DRIVER_CHECK_EN.
- rsp_ready low for 5 cycles after rsp_valid -> rsp_data and rsp_valid stable; cmd_ready=0 throughout; op_count increments only at the handshake.
- decouple_req raised one cycle after accept of 3/4 -> rsp_data=7 delivered, then decouple_ack=1 and rp_reset_n=0; drop decouple_req -> ack=0, rp_reset_n=1, next cmd 1/1 returns 2.
- Reset_n low for 1 edge while in WAIT -> rsp_valid never asserts; all outputs at reset values; op_count=0.
- RP_DRIVER_CHECK_EN, partition forced to return 0x10 for cmd 2/3 -> err=1 and stays 1 across a following correct op.
